// File: rtl/and3_response_checker.sv
// and3_response_checker: self-checking monitor for the 3-input AND datapath (y = a & b & c).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, stop           begin a run (clears results) / end it after in-flight vectors drain
//   a, b, c, vec_valid    stimulus vector applied to the DUT and its valid flag
//   y                     DUT output, expected LATENCY cycles after its vector
//   busy, done            run in progress (RUN or DRAIN) / run finished (DONE)
//   mismatch              one-cycle pulse after each failed compare
//   err_count, chk_count  saturating failed / total compare counters
//   coverage, full_cov    bit {a,b,c} set once that vector was checked / all 8 seen
//   first_fail            {valid, a, b, c} of the first failing vector
module and3_response_checker #(
    parameter int LATENCY = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             vec_valid,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic [7:0]       coverage,
    output logic             full_cov,
    output logic [3:0]       first_fail
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // DRAIN must cover the pipeline depth; a wire-only line still needs one cycle
    localparam int DRAIN_LEN = (LATENCY == 0) ? 1 : LATENCY;

    state_t     state, state_nx;
    logic [2:0] drain_cnt;
    logic [3:0] cur, tap;
    logic       hit, fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
        end
    end

    // start has priority over every other transition, including stop
    always_comb begin
        state_nx = start ? RUN :
                   (state == RUN && stop) ? DRAIN :
                   (state == DRAIN && drain_cnt == 3'(DRAIN_LEN - 1)) ? DONE : state;
        busy     = (state == RUN) || (state == DRAIN);
        done     = (state == DONE);
    end

    // vectors are only accepted in RUN; DRAIN just flushes what is already in flight
    assign cur = {vec_valid && (state == RUN), a, b, c};

    generate
        if (LATENCY == 0) begin : g_wire
            assign tap = cur;
        end else begin : g_line
            logic [3:0] sr [LATENCY];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= start ? 4'd0 : cur;
                    for (int i = 1; i < LATENCY; i++) sr[i] <= start ? 4'd0 : sr[i-1];
                end
            end
            assign tap = sr[LATENCY-1];
        end
    endgenerate

    assign hit  = tap[3];
    assign fail = hit && (y != &tap[2:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch   <= 1'b0;
            err_count  <= '0;
            chk_count  <= '0;
            coverage   <= '0;
            first_fail <= '0;
        end else if (start) begin
            mismatch   <= 1'b0;
            err_count  <= '0;
            chk_count  <= '0;
            coverage   <= '0;
            first_fail <= '0;
        end else begin
            mismatch <= fail;
            if (hit) begin
                if (chk_count != '1) chk_count <= chk_count + CNT_W'(1);
                coverage[tap[2:0]] <= 1'b1;
            end
            if (fail) begin
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
                if (!first_fail[3]) first_fail <= {1'b1, tap[2:0]};
            end
        end
    end

    assign full_cov = &coverage;
endmodule

// File: tb/tb_and3_response_checker.sv
// tb_and3_response_checker: checks two checker instances (LATENCY=0/CNT_W=8 and LATENCY=2/CNT_W=2)
// driven with the same vectors, against table constants and a list-based reference model.
module tb_and3_response_checker;
    logic clk = 0, rst_n = 1, start = 0, stop = 0, a = 0, b = 0, c = 0, vv = 0;
    logic y0, y1, p1 = 0, p2 = 0;
    int   fault = 0;
    int   total = 0, bad = 0, mm0 = 0, mm1 = 0;

    logic       busy0, done0, mis0, fc0, busy1, done1, mis1, fc1;
    logic [7:0] err0, chk0, cov0, cov1;
    logic [1:0] err1, chk1;
    logic [3:0] ff0, ff1;

    logic [2:0] plan[$];

    typedef struct {
        logic [23:0] vs;
        int          n;
        int          gap;
        int          fm;
        int          chk;
        int          err;
        logic [7:0]  cov;
        logic [3:0]  ff;
    } rec_t;

    and3_response_checker #(.LATENCY(0), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a), .b(b), .c(c),
        .vec_valid(vv), .y(y0), .busy(busy0), .done(done0), .mismatch(mis0),
        .err_count(err0), .chk_count(chk0), .coverage(cov0), .full_cov(fc0), .first_fail(ff0)
    );

    and3_response_checker #(.LATENCY(2), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a), .b(b), .c(c),
        .vec_valid(vv), .y(y1), .busy(busy1), .done(done1), .mismatch(mis1),
        .err_count(err1), .chk_count(chk1), .coverage(cov1), .full_cov(fc1), .first_fail(ff1)
    );

    always #5 clk = ~clk;

    // fault 0: correct AND, 1: stuck at 0, 2: inverted; u1 sees a 2-stage pipelined DUT
    always @(posedge clk) begin
        p1 <= a & b & c;
        p2 <= p1;
        if (mis0) mm0++;
        if (mis1) mm1++;
    end
    assign y0 = (fault == 2) ? ~(a & b & c) : (fault == 1) ? 1'b0 : (a & b & c);
    assign y1 = (fault == 2) ? ~p2 : (fault == 1) ? 1'b0 : p2;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // expected results of a run, computed from the list of applied vectors
    task automatic model(input int maxc, output int ec, output int ee, output int nf,
                         output logic [7:0] ecov, output logic [3:0] eff);
        nf = 0; ecov = 0; eff = 0;
        foreach (plan[i]) begin
            logic e, yv;
            e  = &plan[i];
            yv = (fault == 2) ? ~e : (fault == 1) ? 1'b0 : e;
            ecov[plan[i]] = 1'b1;
            if (yv != e) begin
                if (nf == 0) eff = {1'b1, plan[i]};
                nf++;
            end
        end
        ec = (plan.size() > maxc) ? maxc : plan.size();
        ee = (nf > maxc) ? maxc : nf;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy0"}, busy0, 0); chk({tag, " done0"}, done0, 0); chk({tag, " mis0"}, mis0, 0);
        chk({tag, " err0"}, err0, 0);   chk({tag, " chk0"}, chk0, 0);   chk({tag, " cov0"}, cov0, 0);
        chk({tag, " fc0"}, fc0, 0);     chk({tag, " ff0"}, ff0, 0);
        chk({tag, " busy1"}, busy1, 0); chk({tag, " done1"}, done1, 0); chk({tag, " mis1"}, mis1, 0);
        chk({tag, " err1"}, err1, 0);   chk({tag, " chk1"}, chk1, 0);   chk({tag, " cov1"}, cov1, 0);
        chk({tag, " ff1"}, ff1, 0);
    endtask

    // start, apply plan, stop on the cycle after the last vector, wait for done, check u1
    task automatic run(input string tag, input int fm, input int gap);
        int b0, b1, t0, t1, ec, ee, nf;
        logic [7:0] ecov;
        logic [3:0] eff;
        fault = fm;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        b0 = mm0; b1 = mm1;
        chk({tag, " clr chk0"}, chk0, 0); chk({tag, " clr err0"}, err0, 0);
        chk({tag, " clr cov0"}, cov0, 0); chk({tag, " clr ff0"}, ff0, 0);
        chk({tag, " clr chk1"}, chk1, 0); chk({tag, " clr cov1"}, cov1, 0);
        chk({tag, " start busy0"}, busy0, 1); chk({tag, " start done0"}, done0, 0);
        chk({tag, " start busy1"}, busy1, 1); chk({tag, " start done1"}, done1, 0);
        foreach (plan[i]) begin
            {a, b, c} = plan[i];
            vv = 1;
            @(negedge clk) vv = 0;
            repeat (gap) @(negedge clk);
        end
        stop = 1;
        @(negedge clk) stop = 0;
        chk({tag, " drain busy0"}, busy0, 1); chk({tag, " drain done0"}, done0, 0);
        chk({tag, " drain busy1"}, busy1, 1); chk({tag, " drain done1"}, done1, 0);
        // new vectors during DRAIN/DONE must be ignored
        vv = 1;
        t0 = 0; t1 = 0;
        for (int k = 1; k <= 12; k++) begin
            {a, b, c} = 3'($urandom);
            @(negedge clk);
            if (done0 && t0 == 0) t0 = k;
            if (done1 && t1 == 0) t1 = k;
            if (t0 != 0 && t1 != 0) break;
        end
        vv = 0;
        chk({tag, " done delay lat0"}, t0, 1);
        chk({tag, " done delay lat2"}, t1, 2);
        chk({tag, " done busy0"}, busy0, 0); chk({tag, " done busy1"}, busy1, 0);
        repeat (2) @(negedge clk);
        model(3, ec, ee, nf, ecov, eff);
        chk({tag, " chk1"}, chk1, ec); chk({tag, " err1"}, err1, ee);
        chk({tag, " cov1"}, cov1, ecov); chk({tag, " fc1"}, fc1, ecov == 8'hFF);
        chk({tag, " ff1"}, ff1, eff);
        chk({tag, " pulses0"}, mm0 - b0, nf); chk({tag, " pulses1"}, mm1 - b1, nf);
    endtask

    task automatic check_u0(input string tag, input int ec, input int ee,
                            input logic [7:0] ecov, input logic [3:0] eff);
        chk({tag, " chk0"}, chk0, ec); chk({tag, " err0"}, err0, ee);
        chk({tag, " cov0"}, cov0, ecov); chk({tag, " fc0"}, fc0, ecov == 8'hFF);
        chk({tag, " ff0"}, ff0, eff);
    endtask

    initial begin
        rec_t tbl[4];
        tbl[0] = '{24'o76543210, 8, 0, 0, 8, 0, 8'hFF, 4'h0};
        tbl[1] = '{24'o76543210, 8, 0, 1, 8, 1, 8'hFF, 4'hF};
        tbl[2] = '{24'o00015703, 5, 2, 2, 5, 5, 8'hAB, 4'hB};
        tbl[3] = '{24'o00000006, 1, 1, 0, 1, 0, 8'h40, 4'h0};

        #1 rst_n = 0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int t = 0; t < 4; t++) begin
            string tag;
            tag = $sformatf("tbl%0d", t);
            plan.delete();
            for (int i = 0; i < tbl[t].n; i++) plan.push_back(tbl[t].vs[3*i +: 3]);
            run(tag, tbl[t].fm, tbl[t].gap);
            check_u0(tag, tbl[t].chk, tbl[t].err, tbl[t].cov, tbl[t].ff);
        end

        // reset in the middle of a run
        fault = 2;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int i = 0; i < 3; i++) begin
            {a, b, c} = 3'(i + 5);
            vv = 1;
            @(negedge clk);
        end
        vv = 0;
        rst_n = 0;
        #1 check_zero("midreset");
        @(negedge clk) rst_n = 1;
        vv = 1;
        repeat (2) @(negedge clk);
        vv = 0;
        @(negedge clk);
        chk("no start chk0", chk0, 0); chk("no start chk1", chk1, 0);
        chk("no start busy0", busy0, 0);
        plan.delete();
        plan.push_back(3'd5); plan.push_back(3'd2);
        run("after reset", 0, 0);
        check_u0("after reset", 2, 0, 8'h24, 4'h0);

        for (int r = 0; r < 10; r++) begin
            int ec, ee, nf, n;
            logic [7:0] ecov;
            logic [3:0] eff;
            string tag;
            tag = $sformatf("rnd%0d", r);
            plan.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) plan.push_back(3'($urandom));
            run(tag, $urandom_range(0, 2), $urandom_range(0, 2));
            model(255, ec, ee, nf, ecov, eff);
            check_u0(tag, ec, ee, ecov, eff);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
